tx_link_responder: RTL and testbench

Memory-side end of the CPU serial transaction link. It deserializes commands the CPU core shifts out NSHIFT bits per cycle and performs one access per transaction on a simple valid/ready memory port. For reads, it serializes the reply back to the CPU on rx_pins. It pairs with the CPU-side decoder/scheduler TX/RX logic and is used both as the on-board RAM bridge and as the verification responder.

---
 rtl/tx_link_responder.sv | 251 +++++++++++++++++++++++++
 tb/tb_tx_link_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_link_responder.sv
// ---------------------------------------------------------------------------
// tx_link_responder
//
// Memory-side end of the CPU serial transaction link. Commands arrive on
// tx_pins as NSHIFT-bit symbols, LSB first: a start symbol, a command
// symbol {write, wide}, ADDR_BITS/NSHIFT address symbols and, for writes,
// 4 or 8 data symbols. One access is then issued on a valid/ready memory
// port. Reads are answered on rx_pins after REPLY_DELAY idle cycles with a
// start symbol (2'b01) followed by 8 data symbols.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   tx_pins    link symbols from the CPU
//   rx_pins    reply symbols to the CPU (0 except while replying)
//   mem_valid  memory request valid, held until mem_ready
//   mem_write  1 = write, 0 = read
//   mem_wide   1 = 16-bit access, 0 = 8-bit
//   mem_addr   byte address
//   mem_wdata  write data, upper byte 0 for 8-bit writes
//   mem_ready  memory accept/complete, only looked at while mem_valid = 1
//   mem_rdata  read data, valid in the mem_ready cycle
//   busy       transaction in progress (state != IDLE)
//   proto_err  sticky: CPU drove a non-zero symbol while it should be quiet
// ---------------------------------------------------------------------------
module tx_link_responder #(
  parameter int NSHIFT      = 2,
  parameter int REG_BITS    = 8,
  parameter int ADDR_BITS   = 16,
  parameter int REPLY_DELAY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSHIFT-1:0]     tx_pins,
  output logic [NSHIFT-1:0]     rx_pins,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic                  mem_wide,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [2*REG_BITS-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [2*REG_BITS-1:0] mem_rdata,
  output logic                  busy,
  output logic                  proto_err
);

  localparam int DW    = 2 * REG_BITS;
  localparam int CNT_W = 8;

  // Terminal counts (counter runs 0..N-1 within a phase)
  localparam logic [CNT_W-1:0] ADDR_LAST        = CNT_W'(ADDR_BITS / NSHIFT - 1);
  localparam logic [CNT_W-1:0] DATA_LAST_WIDE   = CNT_W'(DW / NSHIFT - 1);
  localparam logic [CNT_W-1:0] DATA_LAST_NARROW = CNT_W'(REG_BITS / NSHIFT - 1);
  localparam logic [CNT_W-1:0] REPLY_LAST       = CNT_W'(DW / NSHIFT - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST       =
    CNT_W'((REPLY_DELAY > 0) ? REPLY_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE          = CNT_W'(1);

  localparam logic [NSHIFT-1:0] SYM_ZERO  = '0;
  localparam logic [NSHIFT-1:0] SYM_START = NSHIFT'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] DELAY  = 3'd5;
  localparam logic [2:0] RSTART = 3'd6;
  localparam logic [2:0] RDATA  = 3'd7;

  logic [2:0]           state_reg,     state_next;
  logic [CNT_W-1:0]     cnt_reg,       cnt_next;
  logic [NSHIFT-1:0]    rx_pins_reg,   rx_pins_next;
  logic                 mem_valid_reg, mem_valid_next;
  logic                 mem_write_reg, mem_write_next;
  logic                 mem_wide_reg,  mem_wide_next;
  logic [ADDR_BITS-1:0] mem_addr_reg,  mem_addr_next;
  logic [DW-1:0]        mem_wdata_reg, mem_wdata_next;
  logic [DW-1:0]        rdata_reg,     rdata_next;
  logic                 busy_reg;
  logic                 proto_err_reg, proto_err_next;

  // Read data as captured: an 8-bit read is zero-extended from the low byte.
  logic [DW-1:0] rdata_ext;

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_rdata_ext
      if (gi < REG_BITS) begin : g_low
        assign rdata_ext[gi] = mem_rdata[gi];
      end else begin : g_high
        assign rdata_ext[gi] = mem_wide_reg & mem_rdata[gi];
      end
    end
  endgenerate

  // CPU must keep its link quiet from the memory access until the reply ends.
  logic quiet_state;
  assign quiet_state = (state_reg == MEM) || (state_reg == DELAY) ||
                       (state_reg == RSTART) || (state_reg == RDATA);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rx_pins_next   = SYM_ZERO;
    mem_valid_next = mem_valid_reg;
    mem_write_next = mem_write_reg;
    mem_wide_next  = mem_wide_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rdata_next     = rdata_reg;
    proto_err_next = proto_err_reg | (quiet_state && (tx_pins != SYM_ZERO));

    case (state_reg)
      IDLE: begin
        if (tx_pins[0]) begin
          state_next = CMD;
        end
      end

      CMD: begin
        mem_write_next = tx_pins[1];
        mem_wide_next  = tx_pins[0];
        // Cleared so a narrow write presents a zero upper byte.
        mem_wdata_next = '0;
        cnt_next       = '0;
        state_next     = ADDR;
      end

      ADDR: begin
        // Shift right so symbol k ends up at addr[2k+1:2k].
        mem_addr_next = {tx_pins, mem_addr_reg[ADDR_BITS-1:NSHIFT]};
        if (cnt_reg == ADDR_LAST) begin
          cnt_next = '0;
          if (mem_write_reg) begin
            state_next = DATA;
          end else begin
            state_next     = MEM;
            mem_valid_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      DATA: begin
        if (mem_wide_reg) begin
          mem_wdata_next = {tx_pins, mem_wdata_reg[DW-1:NSHIFT]};
        end else begin
          mem_wdata_next = {{REG_BITS{1'b0}}, tx_pins,
                            mem_wdata_reg[REG_BITS-1:NSHIFT]};
        end
        if (cnt_reg == (mem_wide_reg ? DATA_LAST_WIDE : DATA_LAST_NARROW)) begin
          cnt_next       = '0;
          state_next     = MEM;
          mem_valid_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      MEM: begin
        if (mem_valid_reg && mem_ready) begin
          mem_valid_next = 1'b0;
          cnt_next       = '0;
          if (mem_write_reg) begin
            state_next = IDLE;
          end else begin
            rdata_next = rdata_ext;
            if (REPLY_DELAY == 0) begin
              state_next   = RSTART;
              rx_pins_next = SYM_START;
            end else begin
              state_next = DELAY;
            end
          end
        end
      end

      DELAY: begin
        if (cnt_reg == DELAY_LAST) begin
          cnt_next     = '0;
          state_next   = RSTART;
          rx_pins_next = SYM_START;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      RSTART: begin
        rx_pins_next = rdata_reg[NSHIFT-1:0];
        rdata_next   = {{NSHIFT{1'b0}}, rdata_reg[DW-1:NSHIFT]};
        cnt_next     = '0;
        state_next   = RDATA;
      end

      RDATA: begin
        if (cnt_reg == REPLY_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          rx_pins_next = rdata_reg[NSHIFT-1:0];
          rdata_next   = {{NSHIFT{1'b0}}, rdata_reg[DW-1:NSHIFT]};
          cnt_next     = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rx_pins_reg   <= '0;
      mem_valid_reg <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_wide_reg  <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rdata_reg     <= '0;
      busy_reg      <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rx_pins_reg   <= rx_pins_next;
      mem_valid_reg <= mem_valid_next;
      mem_write_reg <= mem_write_next;
      mem_wide_reg  <= mem_wide_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rdata_reg     <= rdata_next;
      busy_reg      <= (state_next != IDLE);
      proto_err_reg <= proto_err_next;
    end
  end

  assign rx_pins   = rx_pins_reg;
  assign mem_valid = mem_valid_reg;
  assign mem_write = mem_write_reg;
  assign mem_wide  = mem_wide_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;
  assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_tx_link_responder.sv
// ---------------------------------------------------------------------------
// tb_tx_link_responder
//
// Table-driven bench: each record describes one link transaction (command,
// address, data, memory wait states, expected write data / reply word) plus
// optional protocol-error injection and asynchronous-reset abort cycles.
// Inputs are driven and outputs are checked on the falling clock edge; the
// cycle index c counts from the start-symbol cycle.
// ---------------------------------------------------------------------------
module tb_tx_link_responder;

  localparam int REPLY_DELAY = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  tx_pins;
  logic [1:0]  rx_pins;
  logic        mem_valid;
  logic        mem_write;
  logic        mem_wide;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        proto_err;

  int checks = 0;
  int errors = 0;
  bit err_model = 1'b0;

  tx_link_responder #(
    .NSHIFT     (2),
    .REG_BITS   (8),
    .ADDR_BITS  (16),
    .REPLY_DELAY(REPLY_DELAY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_pins  (tx_pins),
    .rx_pins  (rx_pins),
    .mem_valid(mem_valid),
    .mem_write(mem_write),
    .mem_wide (mem_wide),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          write;
    bit          wide;
    logic [15:0] addr;
    logic [15:0] data;       // value shifted out on the link
    logic [15:0] exp_wdata;  // expected mem_wdata
    logic [15:0] rdata;      // memory read data in the ready cycle
    logic [15:0] exp_reply;  // expected reply word (8 symbols, LSB first)
    int          wait_cyc;   // cycles between mem_valid rise and mem_ready
    int          gap;        // idle cycles before the start symbol
    int          err_cyc;    // cycle to drive 2'b10 (-1: none)
    int          abort_cyc;  // cycle to assert reset (-1: none)
  } txn_t;

  function automatic txn_t mk(input string name, input bit write, input bit wide,
                              input logic [15:0] addr, input logic [15:0] data,
                              input logic [15:0] exp_wdata, input logic [15:0] rdata,
                              input logic [15:0] exp_reply, input int wait_cyc,
                              input int gap, input int err_cyc, input int abort_cyc);
    txn_t t;
    t.name = name; t.write = write; t.wide = wide; t.addr = addr; t.data = data;
    t.exp_wdata = exp_wdata; t.rdata = rdata; t.exp_reply = exp_reply;
    t.wait_cyc = wait_cyc; t.gap = gap; t.err_cyc = err_cyc; t.abort_cyc = abort_cyc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rx_pins"},   32'(rx_pins),   32'h0);
    check({tag, " mem_valid"}, 32'(mem_valid), 32'h0);
    check({tag, " mem_write"}, 32'(mem_write), 32'h0);
    check({tag, " mem_wide"},  32'(mem_wide),  32'h0);
    check({tag, " mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, " mem_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, " busy"},      32'(busy),      32'h0);
    check({tag, " proto_err"}, 32'(proto_err), 32'h0);
  endtask

  // Reset asserted mid-transaction: outputs must clear at once, and no access
  // may follow even with mem_ready held high.
  task automatic do_abort(input string name);
    rst_n     = 1'b0;
    tx_pins   = 2'b00;
    mem_ready = 1'b0;
    #1;
    check_all_zero({name, " abort"});
    err_model = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("%s post-abort %0d mem_valid", name, i), 32'(mem_valid), 32'h0);
      check($sformatf("%s post-abort %0d busy", name, i), 32'(busy), 32'h0);
      mem_ready = 1'b1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic run_txn(input txn_t t);
    int nd, vs, r, rs, last;
    logic [1:0] sym, exp_rx;
    bit aborted;
    nd   = t.write ? (t.wide ? 8 : 4) : 0;
    vs   = 10 + nd;                    // first mem_valid cycle
    r    = vs + t.wait_cyc;            // mem_ready cycle
    rs   = r + 1 + REPLY_DELAY;        // reply start symbol cycle
    last = t.write ? r : rs + 8;       // last busy cycle
    aborted = 1'b0;

    for (int g = 0; g < t.gap; g++) begin
      @(negedge clk);
      check($sformatf("%s gap%0d busy", t.name, g), 32'(busy), 32'h0);
      check($sformatf("%s gap%0d rx_pins", t.name, g), 32'(rx_pins), 32'h0);
      check($sformatf("%s gap%0d mem_valid", t.name, g), 32'(mem_valid), 32'h0);
      tx_pins   = 2'b00;
      mem_ready = 1'b0;
    end

    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      exp_rx = 2'b00;
      if (!t.write && c == rs) exp_rx = 2'b01;
      else if (!t.write && c > rs && c <= rs + 8) exp_rx = t.exp_reply[2*(c-rs-1) +: 2];
      check($sformatf("%s c%0d busy", t.name, c), 32'(busy), 32'(c >= 1 && c <= last));
      check($sformatf("%s c%0d rx_pins", t.name, c), 32'(rx_pins), 32'(exp_rx));
      check($sformatf("%s c%0d mem_valid", t.name, c), 32'(mem_valid), 32'(c >= vs && c <= r));
      check($sformatf("%s c%0d proto_err", t.name, c), 32'(proto_err), 32'(err_model));
      if (c >= vs && c <= r) begin
        check($sformatf("%s c%0d mem_write", t.name, c), 32'(mem_write), 32'(t.write));
        check($sformatf("%s c%0d mem_wide", t.name, c), 32'(mem_wide), 32'(t.wide));
        check($sformatf("%s c%0d mem_addr", t.name, c), 32'(mem_addr), 32'(t.addr));
        if (t.write)
          check($sformatf("%s c%0d mem_wdata", t.name, c), 32'(mem_wdata), 32'(t.exp_wdata));
      end

      sym = 2'b00;
      if (c == 0)            sym = 2'b01;
      else if (c == 1)       sym = {t.write, t.wide};
      else if (c < 10)       sym = t.addr[2*(c-2) +: 2];
      else if (c < 10 + nd)  sym = t.data[2*(c-10) +: 2];
      if (c == t.err_cyc)    sym = 2'b10;
      tx_pins   = sym;
      mem_ready = (c == r);
      mem_rdata = (c == r) ? t.rdata : 16'($urandom);
      if (c == t.err_cyc) err_model = 1'b1;

      if (c == t.abort_cyc) begin
        do_abort(t.name);
        aborted = 1'b1;
        break;
      end
    end
    $display("txn %s %s", t.name, aborted ? "aborted by reset" : "completed");
  endtask

  txn_t tbl [11];

  initial begin
    //            name         wr wd addr      data      exp_wdata rdata     reply     wt gap err abort
    tbl[0]  = mk("write16",    1, 1, 16'hABCD, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 0, 2, -1, -1);
    tbl[1]  = mk("write8",     1, 0, 16'h0010, 16'hABFF, 16'h00FF, 16'h0000, 16'h0000, 0, 1, -1, -1);
    tbl[2]  = mk("read8",      0, 0, 16'h0010, 16'h0000, 16'h0000, 16'hBEA5, 16'h00A5, 3, 1, -1, -1);
    tbl[3]  = mk("read16",     0, 1, 16'h8001, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 0, 1, -1, -1);
    tbl[4]  = mk("b2b_write16",1, 1, 16'h5A5A, 16'hC3C3, 16'hC3C3, 16'h0000, 16'h0000, 1, 0, -1, -1);
    tbl[5]  = mk("b2b_write8", 1, 0, 16'hFFFF, 16'h003C, 16'h003C, 16'h0000, 16'h0000, 0, 0, -1, -1);
    tbl[6]  = mk("read16_err", 0, 1, 16'h0F0F, 16'h0000, 16'h0000, 16'hA55A, 16'hA55A, 3, 1, 11, -1);
    tbl[7]  = mk("abort_addr", 1, 1, 16'h7777, 16'h1111, 16'h1111, 16'h0000, 16'h0000, 0, 1, -1, 5);
    tbl[8]  = mk("abort_rdata",0, 1, 16'h4321, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 0, 1, -1, 15);
    tbl[9]  = mk("write16_rst",1, 1, 16'h1357, 16'h2468, 16'h2468, 16'h0000, 16'h0000, 1, 2, -1, -1);
    tbl[10] = mk("read8_last", 0, 0, 16'h00FE, 16'h0000, 16'h0000, 16'h77C3, 16'h00C3, 2, 0, -1, -1);

    rst_n     = 1'b0;
    tx_pins   = 2'b00;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i]);
    end

    // Quiet tail: the last reply must end with the link back at 0 and idle.
    @(negedge clk);
    tx_pins = 2'b00;
    check("tail busy", 32'(busy), 32'h0);
    check("tail rx_pins", 32'(rx_pins), 32'h0);
    check("tail mem_valid", 32'(mem_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
